// File: rtl/axi_vga_fetch_if.sv
// AXI4 read-address and read-data channels used by the frame fetcher.
interface axi_vga_fetch_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [AXI_ID_W-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic [AXI_ID_W-1:0]   rid;
  logic [1:0]            rresp;
  logic [AXI_DATA_W-1:0] rdata;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rid, rresp, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rid, rresp, rdata, rlast
  );
endinterface

// File: rtl/axi_vga_fetch.sv
// Fetches one frame of TOTAL_BYTE bytes over AXI4 in fixed INCR bursts and scatters the beats
// into up to four destination regions. Define AXI_VGA_FETCH_RRESP_CHECK_EN to abort frames on bad RRESP.
module axi_vga_fetch #(
  parameter int          AXI_ADDR_W    = 32,
  parameter int          AXI_DATA_W    = 64,
  parameter int          AXI_ID_W      = 4,
  parameter int          BURST_BEATS   = 8,
  parameter int          N_REGION      = 3,
  parameter logic [63:0] REGION_LENS   = {16'd0, 16'd300, 16'd2400, 16'd2400},
  parameter int          TOTAL_BYTE    = 5120,
  parameter int          REFRESH_DELAY = 833333
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  axi_vga_fetch_if.master       m_axi,
  input  logic                  cfg_en_i,
  input  logic [AXI_ADDR_W-1:0] cfg_baseaddr_i,
  input  logic                  kick_i,
  output logic                  wr_en_o,
  output logic [1:0]            wr_region_o,
  output logic [15:0]           wr_addr_o,
  output logic [AXI_DATA_W-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);
  localparam int BEAT_BYTES = AXI_DATA_W / 8;
  localparam int BSH        = $clog2(BEAT_BYTES);
  localparam int CW         = $clog2(TOTAL_BYTE + 1);
  localparam int RCW        = $clog2(REFRESH_DELAY + 1);

  function automatic int region_start(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += int'(REGION_LENS[i*16 +: 16]);
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, AR, R, NEXT} state_e;

  state_e                state_q;
  logic [CW-1:0]         byte_cnt_q;
  logic [AXI_ADDR_W-1:0] base_q;
  logic [RCW-1:0]        refresh_q;
  logic                  pending_q;
  logic                  abort_q;
  logic                  err_q;
  logic                  done_q;

  logic start;
  logic refresh_wrap;
  logic beat_acc;
  logic resp_bad;
  logic [31:0] off32;
  logic [N_REGION-1:0] hit;
  logic [N_REGION-1:0][15:0] rel_addr;

  assign start        = (state_q == IDLE) && cfg_en_i && pending_q;
  assign refresh_wrap = (refresh_q == RCW'(REFRESH_DELAY));
  assign beat_acc     = m_axi.rvalid && m_axi.rready;
  assign off32        = 32'(byte_cnt_q);

`ifdef AXI_VGA_FETCH_RRESP_CHECK_EN
  assign resp_bad = (m_axi.rresp != 2'b00);
`else
  assign resp_bad = 1'b0;
`endif

  assign m_axi.arvalid = (state_q == AR);
  assign m_axi.araddr  = base_q + AXI_ADDR_W'(byte_cnt_q);
  assign m_axi.arlen   = 8'(BURST_BEATS - 1);
  assign m_axi.arsize  = 3'(BSH);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arid    = '0;
  assign m_axi.rready  = (state_q == R);

  // Each region owns the half-open byte window [start, start+len) of the frame.
  for (genvar gi = 0; gi < N_REGION; gi++) begin : g_region
    localparam int LO = region_start(gi);
    localparam int HI = LO + int'(REGION_LENS[gi*16 +: 16]);
    assign hit[gi]      = (off32 >= 32'(LO)) && (off32 < 32'(HI));
    assign rel_addr[gi] = 16'((off32 - 32'(LO)) >> BSH);
  end

  always_comb begin
    wr_region_o = '0;
    wr_addr_o   = '0;
    for (int k = 0; k < N_REGION; k++) begin
      if (hit[k]) begin
        wr_region_o = 2'(k);
        wr_addr_o   = rel_addr[k];
      end
    end
    // Once a burst has gone bad its remaining beats are drained without writing.
    wr_en_o = beat_acc && (|hit) && !resp_bad && !abort_q;
  end

  assign wr_data_o    = m_axi.rdata;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      base_q     <= '0;
      refresh_q  <= '0;
      pending_q  <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      refresh_q <= refresh_wrap ? '0 : refresh_q + 1'b1;
      // A request landing on the start cycle is kept rather than swallowed.
      if (refresh_wrap || kick_i) pending_q <= 1'b1;
      else if (start)             pending_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= AR;
            byte_cnt_q <= '0;
            base_q     <= cfg_baseaddr_i;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        AR: begin
          if (m_axi.arready) state_q <= R;
        end
        R: begin
          if (beat_acc) begin
            byte_cnt_q <= byte_cnt_q + CW'(BEAT_BYTES);
            if (resp_bad) begin
              abort_q <= 1'b1;
              err_q   <= 1'b1;
            end
            if (m_axi.rlast) state_q <= NEXT;
          end
        end
        NEXT: begin
          if ((byte_cnt_q == CW'(TOTAL_BYTE)) || !cfg_en_i || abort_q) begin
            state_q <= IDLE;
            done_q  <= (byte_cnt_q == CW'(TOTAL_BYTE)) && !abort_q;
          end else begin
            state_q <= AR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_vga_fetch.sv
// Randomized AXI slave plus frame-level reference model for axi_vga_fetch; directed scenario steps.
`timescale 1ns/1ps
module tb_axi_vga_fetch;
  localparam int AW = 32, DW = 64, IW = 4;
  localparam int BEATS = 8, BB = DW / 8, TOTAL = 5120;
  localparam int NBURST = TOTAL / (BEATS * BB);
  localparam int NBEAT = TOTAL / BB;
`ifdef AXI_VGA_FETCH_RRESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  int region_len [3] = '{2400, 2400, 300};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_en = 1'b0;
  logic kick = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic wr_en;
  logic [1:0] wr_region;
  logic [15:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic busy, frame_done, err;

  always #5 clk = ~clk;

  axi_vga_fetch_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)) axi ();

  axi_vga_fetch #(.REFRESH_DELAY(100)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_axi(axi),
    .cfg_en_i(cfg_en), .cfg_baseaddr_i(cfg_base), .kick_i(kick),
    .wr_en_o(wr_en), .wr_region_o(wr_region), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .frame_done_o(frame_done), .err_o(err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC3A5_5A3C, ~a + 32'd7};
  endfunction

  // Reference model / slave bookkeeping
  int frame_no = 0, frames_ended = 0, ar_idx = 0, ar_total = 0, beats_f = 0, beat_i = 0;
  int idle_cyc = 0, last_gap = 0, last_beats = 0, last_r2 = -1;
  int reg_cnt [3];
  int hold_burst = -1, hold_cnt = 0, hold_stall = 0, inj_frame = -1;
  bit busy_prev = 1'b0, in_err = 1'b0, ar_wait = 1'b0, last_done = 1'b0, r_acc = 1'b0;
  logic [31:0] exp_base = '0, ar_hold_addr = '0, first_ar_addr = '0;
  logic [31:0] burst_q [$];

  initial begin : bus_model
    int off, k, s, rel;
    bit bad, exp_wr, complete;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rresp = 2'b00; axi.rdata = '0; axi.rid = '0;
    forever begin
      @(negedge clk);
      r_acc = 1'b0;
      if (!rst_n) begin
        burst_q.delete();
        beat_i = 0; ar_idx = 0; beats_f = 0; in_err = 1'b0;
        ar_wait = 1'b0; busy_prev = 1'b0; idle_cyc = 0;
      end else begin
        if (busy && !busy_prev) begin
          frame_no++;
          exp_base = cfg_base; ar_idx = 0; beats_f = 0; in_err = 1'b0;
          reg_cnt = '{0, 0, 0}; last_r2 = -1; last_gap = idle_cyc;
          chk("err_at_start", 64'(err), 64'd0);
        end
        if (axi.arvalid) begin
          if (ar_wait) begin
            chk("araddr_stable", 64'(axi.araddr), 64'(ar_hold_addr));
          end else begin
            chk("araddr", 64'(axi.araddr), 64'(exp_base + 32'(ar_idx * BEATS * BB)));
            chk("ar_attr", 64'({axi.arlen, axi.arsize, axi.arburst, axi.arid}),
                64'({8'd7, 3'd3, 2'd1, 4'd0}));
            chk("ar_count", 64'(ar_idx < NBURST), 64'd1);
          end
          if (axi.arready) begin
            if (ar_idx == 0) first_ar_addr = axi.araddr;
            burst_q.push_back(axi.araddr);
            ar_idx++; ar_total++; ar_wait = 1'b0;
          end else begin
            ar_wait = 1'b1; ar_hold_addr = axi.araddr;
            if (ar_idx == hold_burst) hold_stall++;
          end
        end else if (ar_wait) begin
          chk("arvalid_held", 64'(axi.arvalid), 64'd1);
          ar_wait = 1'b0;
        end
        if (axi.rvalid && axi.rready) begin
          r_acc = 1'b1;
          off = beats_f * BB; k = -1; s = 0; rel = 0;
          for (int r = 0; r < 3; r++) begin
            if (off >= s && off < s + region_len[r]) begin
              k = r; rel = (off - s) / BB;
            end
            s += region_len[r];
          end
          bad = RESP_CHK && (in_err || axi.rresp != 2'b00);
          exp_wr = (k >= 0) && !bad;
          chk("wr_en", 64'(wr_en), 64'(exp_wr));
          if (exp_wr && wr_en) begin
            chk("wr_region", 64'(wr_region), 64'(k));
            chk("wr_addr", 64'(wr_addr), 64'(rel));
            chk("wr_data", 64'(wr_data), mem_word(exp_base + 32'(off)));
            reg_cnt[k]++;
            if (k == 2) last_r2 = rel;
          end
          if (RESP_CHK && axi.rresp != 2'b00) in_err = 1'b1;
          beats_f++; beat_i++;
          if (axi.rlast) begin
            beat_i = 0;
            void'(burst_q.pop_front());
          end
        end else begin
          chk("wr_idle", 64'(wr_en), 64'd0);
        end
        if (!busy && busy_prev) begin
          complete = (beats_f == NBEAT) && !in_err;
          chk("frame_done", 64'(frame_done), 64'(complete));
          chk("err_o", 64'(err), 64'(in_err));
          if (complete) begin
            for (int r = 0; r < 3; r++)
              chk($sformatf("reg%0d_cnt", r), 64'(reg_cnt[r]), 64'((region_len[r] + BB - 1) / BB));
            chk("reg2_last_addr", 64'(last_r2), 64'((region_len[2] - 1) / BB));
            chk("bursts", 64'(ar_idx), 64'(NBURST));
          end
          last_beats = beats_f; last_done = frame_done; frames_ended++; idle_cyc = 0;
          $display("frame %0d end: base=%08h bursts=%0d beats=%0d done=%0b err=%0b",
                   frame_no, exp_base, ar_idx, beats_f, frame_done, err);
        end else begin
          chk("done_quiet", 64'(frame_done), 64'd0);
        end
        if (!busy) idle_cyc++;
        busy_prev = busy;
      end

      @(posedge clk); #1;
      if (!rst_n) begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      end else begin
        if (axi.arvalid && ar_idx == hold_burst && hold_cnt < 20) begin
          axi.arready = 1'b0; hold_cnt++;
        end else begin
          axi.arready = ($urandom_range(0, 3) != 0);
        end
        if (axi.rvalid && !r_acc) begin
          // beat still pending: hold it
        end else if (burst_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = mem_word(burst_q[0] + 32'(beat_i * BB));
          axi.rlast  = (beat_i == BEATS - 1);
          axi.rresp  = (frame_no == inj_frame && ar_idx - 1 == 5 && beat_i == 2) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        end
      end
    end
  end

  task automatic wait_started(input int n);
    int c = 0;
    while (frame_no < n && c < 6000) begin @(posedge clk); #2; c++; end
    chk("wait_frame_start", 64'(frame_no >= n), 64'd1);
  endtask

  task automatic wait_ended(input int n);
    int c = 0;
    while (frames_ended < n && c < 6000) begin @(posedge clk); #2; c++; end
    chk("wait_frame_end", 64'(frames_ended >= n), 64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c, snap, fs;
    rst_n = 1'b0; cfg_en = 1'b0; kick = 1'b0; cfg_base = 32'h8000_0000;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Frame 1: refresh-triggered, burst 2 stalled 20 cycles, base changed mid-frame.
    rst_n = 1'b1; cfg_en = 1'b1; hold_burst = 2;
    wait_started(1);
    c = 0;
    while (beats_f < 200 && c < 3000) begin @(posedge clk); #2; c++; end
    cfg_base = 32'h9000_0000;
    wait_ended(1);
    chk("f1_done", 64'(last_done), 64'd1);
    chk("f1_beats", 64'(last_beats), 64'(NBEAT));
    chk("ar_hold_cycles", 64'(hold_stall >= 20), 64'd1);
    hold_burst = -1;

    // Frame 2: kick during beat 3, next frame must follow promptly.
    wait_started(2);
    c = 0;
    while (beats_f < 3 && c < 3000) begin @(posedge clk); #2; c++; end
    kick = 1'b1;
    @(posedge clk); #2;
    kick = 1'b0;
    wait_ended(2);
    wait_started(3);
    chk("kick_gap", 64'(last_gap <= 2), 64'd1);

    // Frame 3: disable during burst 10.
    c = 0;
    while (ar_idx < 11 && c < 3000) begin @(posedge clk); #2; c++; end
    cfg_en = 1'b0;
    wait_ended(3);
    chk("dis_beats", 64'(last_beats), 64'(11 * BEATS));
    chk("dis_done", 64'(last_done), 64'd0);
    snap = ar_total;
    repeat (300) @(posedge clk);
    #2;
    chk("dis_idle_busy", 64'(busy), 64'd0);
    chk("dis_no_ar", 64'(ar_total), 64'(snap));
    cfg_en = 1'b1;

    // Frames 4/5: SLVERR injected on burst 5 beat 2 of frame 5.
    wait_started(4);
    inj_frame = 5;
    wait_ended(4);
    chk("f4_done", 64'(last_done), 64'd1);
    wait_ended(5);
    chk("f5_done", 64'(last_done), RESP_CHK ? 64'd0 : 64'd1);
    chk("f5_beats", 64'(last_beats), RESP_CHK ? 64'd48 : 64'(NBEAT));
    wait_started(6);
    chk("err_cleared", 64'(err), 64'd0);

    // Frame 6: asynchronous reset mid-burst.
    c = 0;
    while (!(axi.rready && beats_f >= 20) && c < 3000) begin @(posedge clk); #2; c++; end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("arst_rready", 64'(axi.rready), 64'd0);
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_frame_done", 64'(frame_done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    snap = frames_ended; fs = frame_no;
    @(posedge clk); #2;
    kick = 1'b1;
    @(posedge clk); #2;
    kick = 1'b0;
    wait_started(fs + 1);
    c = 0;
    while (ar_idx < 1 && c < 200) begin @(posedge clk); #2; c++; end
    chk("rst_first_ar", 64'(first_ar_addr), 64'(cfg_base));
    wait_ended(snap + 1);
    chk("post_rst_done", 64'(last_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
